// File: rtl/sram_access_ctrl.sv
// Single-port SRAM sequencer: precharge -> wordline (+write drive) -> sense -> one-cycle response.
// Define SRAM_PARITY_EN to add an even-parity column on wr_bits/sense_in and the rsp_err output.
module sram_access_ctrl #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int T_PRE   = 2,
    parameter int T_WL    = 2,
    parameter int T_SENSE = 1,
    localparam int ROWS   = 1 << ADDR_W,
`ifdef SRAM_PARITY_EN
    localparam int CW     = DATA_W + 1
`else
    localparam int CW     = DATA_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              pre,
    output logic [ROWS-1:0]   wl,
    output logic              wde,
    output logic [CW-1:0]     wr_bits,
    output logic              sae,
`ifdef SRAM_PARITY_EN
    output logic              rsp_err,
`endif
    input  logic [CW-1:0]     sense_in
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ACC   = 3'd2;
    localparam logic [2:0] S_SENSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int T_MAX = (T_PRE > T_WL) ? ((T_PRE > T_SENSE) ? T_PRE : T_SENSE)
                                          : ((T_WL > T_SENSE) ? T_WL : T_SENSE);
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     wr_bits_q, wr_bits_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              pre_q, pre_d;
    logic              wde_q, wde_d;
    logic              sae_q, sae_d;
    logic [ROWS-1:0]   wl_q, wl_d;
    logic [CW-1:0]     wr_word;
    logic              accept;

`ifdef SRAM_PARITY_EN
    logic err_q, err_d;
    assign wr_word = {^req_wdata, req_wdata};
`else
    assign wr_word = req_wdata;
`endif

    assign accept = req_valid & req_ready_q;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wr_bits_d = wr_bits_q;
        rdata_d   = rdata_q;
`ifdef SRAM_PARITY_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                state_d   = S_PRE;
                cnt_d     = CNT_W'(T_PRE - 1);
                we_d      = req_we;
                addr_d    = req_addr;
                wr_bits_d = wr_word;
            end
            S_PRE: if (cnt_q == '0) begin
                state_d = S_ACC;
                cnt_d   = CNT_W'(T_WL - 1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_ACC: if (cnt_q == '0) begin
                if (we_q) begin
                    state_d = S_DONE;
`ifdef SRAM_PARITY_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_SENSE;
                    cnt_d   = CNT_W'(T_SENSE - 1);
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_SENSE: if (cnt_q == '0) begin
                state_d = S_DONE;
                rdata_d = sense_in[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                err_d   = ^sense_in;
`endif
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Control outputs decode the next state so they come straight from flops, aligned with state_q.
        pre_d       = (state_d == S_PRE);
        wde_d       = (state_d == S_ACC) && we_d;
        sae_d       = (state_d == S_SENSE);
        rsp_valid_d = (state_d == S_DONE);
        req_ready_d = (state_d == S_IDLE);
        wl_d        = '0;
        if (state_d == S_ACC || state_d == S_SENSE) wl_d[addr_d] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wr_bits_q   <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            pre_q       <= 1'b0;
            wde_q       <= 1'b0;
            sae_q       <= 1'b0;
            wl_q        <= '0;
`ifdef SRAM_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wr_bits_q   <= wr_bits_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            pre_q       <= pre_d;
            wde_q       <= wde_d;
            sae_q       <= sae_d;
            wl_q        <= wl_d;
`ifdef SRAM_PARITY_EN
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign pre       = pre_q;
    assign wl        = wl_q;
    assign wde       = wde_q;
    assign sae       = sae_q;
    assign wr_bits   = wr_bits_q;
`ifdef SRAM_PARITY_EN
    assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: random requests against a timing-profile reference model and a
// behavioural cell array; set SRAM_PARITY_EN to exercise the parity column.
`timescale 1ns/1ps
module tb_sram_access_ctrl;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 8;
    localparam int T_PRE   = 2;
    localparam int T_WL    = 2;
    localparam int T_SENSE = 1;
    localparam int ROWS    = 1 << ADDR_W;
`ifdef SRAM_PARITY_EN
    localparam int CW      = DATA_W + 1;
`else
    localparam int CW      = DATA_W;
`endif
    localparam int LAT_WR  = T_PRE + T_WL + 1;
    localparam int LAT_RD  = LAT_WR + T_SENSE;
    localparam int VW      = ROWS + 5 + CW;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CW-1:0]     wbits;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        int                acc_cyc;
    } txn_t;

    txn_t sb_q[$];

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              pre, wde, sae;
    logic [ROWS-1:0]   wl;
    logic [CW-1:0]     wr_bits, sense_in;
`ifdef SRAM_PARITY_EN
    logic              rsp_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [CW-1:0]     cells [ROWS];
    logic [DATA_W-1:0] ref_mem [ROWS];
    logic [CW-1:0]     last_wr;
    logic [DATA_W-1:0] last_rdata;
    logic              sense_flip;
    logic [CW-1:0]     junk;
    int                row_sel;

    logic              e_pre, e_wde, e_sae, e_rdy, e_rsp;
    logic [ROWS-1:0]   e_wl;
    logic [CW-1:0]     e_wr;
    logic [DATA_W-1:0] e_rdata;
    logic [VW-1:0]     m_got, m_exp;
    int                k, lat;

    sram_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_PRE(T_PRE), .T_WL(T_WL), .T_SENSE(T_SENSE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .pre(pre), .wl(wl), .wde(wde), .wr_bits(wr_bits), .sae(sae),
`ifdef SRAM_PARITY_EN
        .rsp_err(rsp_err),
`endif
        .sense_in(sense_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] to_bits(input logic [DATA_W-1:0] d);
`ifdef SRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Cell array: write drivers store wr_bits into the selected row; sense amps return it, junk otherwise.
    always_comb begin
        row_sel = 0;
        for (int i = 0; i < ROWS; i++) if (wl[i]) row_sel = i;
    end

    always_comb begin
        if (sae) begin
            sense_in = cells[row_sel];
`ifdef SRAM_PARITY_EN
            if (sense_flip) sense_in[DATA_W] = ~sense_in[DATA_W];
`endif
        end else begin
            sense_in = junk;
        end
    end

    always @(posedge clk) begin
        junk <= CW'($urandom);
        if (wde) cells[row_sel] <= wr_bits;
    end

    // Monitor: the in-flight transaction fixes what every output must show in each cycle after accept.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            e_pre = 1'b0; e_wl = '0; e_wde = 1'b0; e_sae = 1'b0;
            e_rdy = 1'b1; e_rsp = 1'b0; e_wr = last_wr;
            k = 0; lat = 0;
            if (sb_q.size() > 0) begin
                k   = cyc - sb_q[0].acc_cyc;
                lat = sb_q[0].we ? LAT_WR : LAT_RD;
            end
            if (k >= 1) begin
                e_rdy = 1'b0;
                e_wr  = sb_q[0].wbits;
                e_pre = (k <= T_PRE);
                if (k > T_PRE && k < lat) e_wl = ROWS'(1) << sb_q[0].addr;
                e_wde = sb_q[0].we && k > T_PRE && k < lat;
                e_sae = !sb_q[0].we && k > T_PRE + T_WL && k < lat;
                e_rsp = (k >= lat);
            end
            m_exp = {e_pre, e_wl, e_wde, e_sae, e_rdy, e_rsp, e_wr};
            m_got = {pre, wl, wde, sae, req_ready, rsp_valid, wr_bits};
            check("ctrl", 64'(m_got), 64'(m_exp));
            if (e_rsp) begin
                if (sb_q[0].we) begin
                    e_rdata = last_rdata;
                    ref_mem[sb_q[0].addr] = sb_q[0].wbits[DATA_W-1:0];
                end else begin
                    e_rdata    = sb_q[0].exp_rdata;
                    last_rdata = e_rdata;
                end
                check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
`ifdef SRAM_PARITY_EN
                check("rsp_err", 64'(rsp_err), 64'(sb_q[0].exp_err));
`endif
                last_wr = sb_q[0].wbits;
                void'(sb_q.pop_front());
            end
        end
    end

    // Present one request and hold it until the controller takes it; returns just after the accept edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic flip);
        txn_t t;
        bit   ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1 && rst_n === 1'b1) begin
                t.we        = we;
                t.addr      = addr;
                t.wbits     = to_bits(data);
                t.exp_rdata = ref_mem[addr];
                t.exp_err   = !we && flip;
                t.acc_cyc   = cyc;
                sense_flip  = flip;
                sb_q.push_back(t);
                ok = 1'b1;
            end
        end
        check("accept", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = DATA_W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_during_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bit seen = 1'b0;
        issue(1'b1, addr, data, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (wl != '0);
        end
        check("reach_acc", 64'(seen), 64'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({pre, wl, wde, sae, rsp_valid, wr_bits, rsp_rdata}), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
`ifdef SRAM_PARITY_EN
        check("rst_err", 64'(rsp_err), 64'(0));
`endif
        sb_q.delete();
        last_wr    = '0;
        last_rdata = '0;
        // The interrupted write leaves this row undefined; restore it to the model's content.
        cells[addr] <= to_bits(ref_mem[addr]);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic              r_we;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_data;
        logic              r_flip;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        sense_flip = 1'b0; last_wr = '0; last_rdata = '0;
        for (int i = 0; i < ROWS; i++) begin
            ref_mem[i] = '0;
            cells[i]  <= '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_ctrl", 64'({pre, wl, wde, sae, rsp_valid, wr_bits, rsp_rdata}), 64'(0));
        check("init_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b1, 2'd2, 8'hA5, 1'b0);
        idle(7);
        issue(1'b0, 2'd2, 8'h00, 1'b0);
        idle(8);
        // Requests presented while busy: each waits for ready, one response per accept.
        issue(1'b1, 2'd0, 8'h3C, 1'b0);
        issue(1'b1, 2'd1, 8'hC3, 1'b0);
        issue(1'b0, 2'd0, 8'h00, 1'b0);
        issue(1'b0, 2'd1, 8'h00, 1'b0);
        idle(8);

        reset_during_write(2'd1, 8'h77);
        issue(1'b0, 2'd2, 8'h00, 1'b0);
        idle(8);

`ifdef SRAM_PARITY_EN
        issue(1'b1, 2'd3, 8'h01, 1'b0);
        check("parity_bit", 64'(wr_bits[DATA_W]), 64'(1));
        idle(7);
        issue(1'b0, 2'd3, 8'h00, 1'b1);
        idle(8);
        issue(1'b0, 2'd3, 8'h00, 1'b0);
        idle(8);
`endif

        for (int n = 0; n < 80; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = ADDR_W'($urandom);
            r_data = DATA_W'($urandom);
`ifdef SRAM_PARITY_EN
            r_flip = !r_we && ($urandom_range(0, 3) == 0);
`else
            r_flip = 1'b0;
`endif
            issue(r_we, r_addr, r_data, r_flip);
            idle($urandom_range(0, 2));
        end

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
        check("drain", 64'(sb_q.size()), 64'(0));
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
